// File: rtl/car_status_gen.sv
// Vehicle status producer: overheat monitor with hysteresis, trip-distance FSM and saturating fuel counter.
// Define CAR_TEMP_DEBOUNCE_EN to require DEB consecutive hot samples before overheat is flagged.
module car_status_gen #(
  parameter logic [7:0]  HOT_ON  = 8'd90,
  parameter logic [7:0]  HOT_OFF = 8'd80,
  parameter int unsigned DEB     = 3,
  parameter int unsigned DIST_W  = 16,
  parameter int unsigned FUEL_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [7:0]        temp,
  input  logic              trip_load,
  input  logic [DIST_W-1:0] trip_len,
  input  logic              odo_tick,
  input  logic              refill,
  input  logic [FUEL_W-1:0] fuel_add,
  output logic              cpu_overheated,
  output logic              arrived,
  output logic              gas_tank_empty,
  output logic [DIST_W-1:0] remaining,
  output logic [FUEL_W-1:0] fuel
);

  if (HOT_OFF >= HOT_ON || DEB < 1 || DEB > 15) begin : g_param_check
    $error("car_status_gen: requires HOT_OFF < HOT_ON and 1 <= DEB <= 15");
  end

  typedef enum logic [1:0] {IDLE, DRIVING, ARRIVED} trip_state_e;

  trip_state_e       state_q, state_d;
  logic [DIST_W-1:0] remaining_q, remaining_d;
  logic [FUEL_W-1:0] fuel_q, fuel_d;
  logic [FUEL_W:0]   fuel_sum;
  logic              hot_q, hot_d;
  logic              accepted;

`ifdef CAR_TEMP_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEB - 1);
  logic [3:0] hot_cnt_q, hot_cnt_d;
`endif

  // A tick only counts if there was fuel before this cycle's update.
  assign accepted = odo_tick && (fuel_q != '0);

  always_comb begin
    hot_d = hot_q;
`ifdef CAR_TEMP_DEBOUNCE_EN
    hot_cnt_d = hot_cnt_q;
`endif
    if (temp_valid) begin
      if (!hot_q) begin
        if (temp >= HOT_ON) begin
`ifdef CAR_TEMP_DEBOUNCE_EN
          if (hot_cnt_q == DEB_LAST) begin
            hot_d     = 1'b1;
            hot_cnt_d = '0;
          end else begin
            hot_cnt_d = hot_cnt_q + 4'd1;
          end
`else
          hot_d = 1'b1;
`endif
        end else begin
`ifdef CAR_TEMP_DEBOUNCE_EN
          hot_cnt_d = '0;
`endif
        end
      end else if (temp <= HOT_OFF) begin
        hot_d = 1'b0;
      end
    end
  end

  // Load wins over a same-cycle tick for distance, but the tick still burns fuel below.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (trip_load) begin
      remaining_d = trip_len;
      state_d     = (trip_len != '0) ? DRIVING : ARRIVED;
    end else if (state_q == DRIVING && accepted) begin
      remaining_d = remaining_q - DIST_W'(1);
      if (remaining_q == DIST_W'(1)) begin
        state_d = ARRIVED;
      end
    end
  end

  // One extra bit catches refill overflow; an accepted tick can never underflow.
  always_comb begin
    fuel_sum = {1'b0, fuel_q} + (refill ? {1'b0, fuel_add} : '0) - {{FUEL_W{1'b0}}, accepted};
    fuel_d   = fuel_sum[FUEL_W] ? '1 : fuel_sum[FUEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      fuel_q      <= '0;
      hot_q       <= 1'b0;
`ifdef CAR_TEMP_DEBOUNCE_EN
      hot_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      fuel_q      <= fuel_d;
      hot_q       <= hot_d;
`ifdef CAR_TEMP_DEBOUNCE_EN
      hot_cnt_q   <= hot_cnt_d;
`endif
    end
  end

  assign cpu_overheated = hot_q;
  assign arrived        = (state_q == ARRIVED);
  assign gas_tank_empty = (fuel_q == '0);
  assign remaining      = remaining_q;
  assign fuel           = fuel_q;

endmodule

// File: tb/tb_car_status_gen.sv
// Randomized and directed bench for car_status_gen, checked every cycle against a behavioural model.
module tb_car_status_gen;
  localparam int DIST_W = 16;
  localparam int FUEL_W = 8;
  localparam int DEB    = 3;
`ifdef CAR_TEMP_DEBOUNCE_EN
  localparam int DEB_EFF = DEB;
`else
  localparam int DEB_EFF = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              temp_valid;
  logic [7:0]        temp;
  logic              trip_load;
  logic [DIST_W-1:0] trip_len;
  logic              odo_tick;
  logic              refill;
  logic [FUEL_W-1:0] fuel_add;
  logic              cpu_overheated;
  logic              arrived;
  logic              gas_tank_empty;
  logic [DIST_W-1:0] remaining;
  logic [FUEL_W-1:0] fuel;

  int checks = 0;
  int errors = 0;

  // Model state: a trip is "arrived" once loaded with nothing left to drive.
  bit m_valid  = 0;
  bit m_hot    = 0;
  int m_run    = 0;
  bit m_loaded = 0;
  int m_rem    = 0;
  int m_fuel   = 0;

  always #5 clk = ~clk;

  car_status_gen #(
    .HOT_ON(8'd90), .HOT_OFF(8'd80), .DEB(DEB), .DIST_W(DIST_W), .FUEL_W(FUEL_W)
  ) dut (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp(temp),
    .trip_load(trip_load), .trip_len(trip_len), .odo_tick(odo_tick),
    .refill(refill), .fuel_add(fuel_add),
    .cpu_overheated(cpu_overheated), .arrived(arrived), .gas_tank_empty(gas_tank_empty),
    .remaining(remaining), .fuel(fuel)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate();
    bit acc;
    if (reset) begin
      m_valid = 1; m_hot = 0; m_run = 0; m_loaded = 0; m_rem = 0; m_fuel = 0;
      return;
    end
    if (temp_valid) begin
      if (!m_hot) begin
        if (temp >= 90) begin
          m_run++;
          if (m_run >= DEB_EFF) begin m_hot = 1; m_run = 0; end
        end else m_run = 0;
      end else if (temp <= 80) m_hot = 0;
    end
    acc = odo_tick && (m_fuel > 0);
    if (trip_load) begin
      m_loaded = 1; m_rem = int'(trip_len);
    end else if (acc && m_loaded && m_rem > 0) m_rem--;
    m_fuel = m_fuel + (refill ? int'(fuel_add) : 0) - int'(acc);
    if (m_fuel > 255) m_fuel = 255;
  endtask

  task automatic applyStimulus(input bit r, input bit tv, input int t, input bit tl,
                               input int len, input bit ot, input bit rf, input int add);
    reset = r; temp_valid = tv; temp = 8'(t); trip_load = tl; trip_len = DIST_W'(len);
    odo_tick = ot; refill = rf; fuel_add = FUEL_W'(add);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cpu_overheated", cpu_overheated, m_hot);
      checkOutput("arrived", arrived, (m_loaded && m_rem == 0));
      checkOutput("gas_tank_empty", gas_tank_empty, (m_fuel == 0));
      checkOutput("remaining", remaining, m_rem);
      checkOutput("fuel", fuel, m_fuel);
    end
  end

  initial begin
    int seq[6];
    bit expHot[6];
    seq = '{95, 95, 50, 95, 95, 95};
`ifdef CAR_TEMP_DEBOUNCE_EN
    expHot = '{0, 0, 0, 0, 0, 1};
`else
    expHot = '{1, 1, 0, 1, 1, 1};
`endif

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_overheat", cpu_overheated, 0);
    checkOutput("rst_arrived", arrived, 0);
    checkOutput("rst_empty", gas_tank_empty, 1);
    checkOutput("rst_remaining", remaining, 0);
    checkOutput("rst_fuel", fuel, 0);

    foreach (seq[i]) begin
      applyStimulus(0, 1, seq[i], 0, 0, 0, 0, 0);
      checkOutput($sformatf("deb_sample%0d", i), cpu_overheated, expHot[i]);
    end
    applyStimulus(0, 1, 85, 0, 0, 0, 0, 0);
    checkOutput("hyst_hold", cpu_overheated, 1);
    applyStimulus(0, 1, 80, 0, 0, 0, 0, 0);
    checkOutput("hyst_clear", cpu_overheated, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
    checkOutput("refill5", fuel, 5);
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0);
    checkOutput("load3_rem", remaining, 3);
    checkOutput("load3_arr", arrived, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("trip_rem%0d", i), remaining, 2 - i);
      checkOutput($sformatf("trip_arr%0d", i), arrived, (i == 2));
    end
    checkOutput("trip_fuel", fuel, 2);

    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("arr_burn_fuel", fuel, 1);
    checkOutput("arr_burn_rem", remaining, 0);
    applyStimulus(0, 0, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("empty_rem", remaining, 3);
    checkOutput("empty_flag", gas_tank_empty, 1);
    checkOutput("empty_arr", arrived, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 254);
    checkOutput("fuel254", fuel, 254);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 10);
    checkOutput("fuel_sat", fuel, 255);
    checkOutput("sat_tick_rem", remaining, 2);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("zero_trip_arr", arrived, 1);
    checkOutput("zero_trip_rem", remaining, 0);

    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 100, 0, 0, 0, 0, 0);
    checkOutput("mid_rem", remaining, 7);
    checkOutput("mid_hot", cpu_overheated, 1);
    applyStimulus(1, 1, 100, 1, 9, 1, 1, 3);
    checkOutput("mid_rst_hot", cpu_overheated, 0);
    checkOutput("mid_rst_arr", arrived, 0);
    checkOutput("mid_rst_empty", gas_tank_empty, 1);
    checkOutput("mid_rst_rem", remaining, 0);
    checkOutput("mid_rst_fuel", fuel, 0);

    for (int i = 0; i < 3000; i++) begin
      bit rf;
      int add;
      rf  = ($urandom_range(7, 0) == 0);
      add = ($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : int'($urandom_range(8, 1));
      applyStimulus(($urandom_range(127, 0) == 0), $urandom_range(1, 0) == 1,
                    int'($urandom_range(110, 60)), ($urandom_range(15, 0) == 0),
                    int'($urandom_range(12, 0)), $urandom_range(1, 0) == 1, rf, add);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
